uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the 16-entry TX FIFO. It pops one byte at a time from the FIFO and shifts it out on `txd` as an asynchronous serial frame: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from a programmable clock-cycle divisor, and frame format comes from a 16550-style line-control byte.

## Interface
Parameters:
- `DIV_W`, default 16: width of the `divisor` input.

Ports:
- `clk` input, 1: system clock.
- `rstn` input, 1: reset, asynchronous, active-low.
- `fifo_empty` input, 1: FIFO empty flag.
- `fifo_data` input, 8: FIFO head data; valid whenever `fifo_empty` = 0.
- `fifo_pop` output, 1: one-cycle pop strobe to the FIFO.
- `divisor` input, `DIV_W`: clock cycles per bit; 0 is treated as 1.
- `lcr` input, 7: line control.
  - [1:0] word length: 00=5, 01=6, 10=7, 11=8.
  - [2] stop bits: 0=1, 1=2.
  - [3] parity enable.
  - [4] even parity.
  - [5] stick parity.
  - [6] break.
- `txd` output, 1: serial line, idle high.
- `tx_busy` output, 1: high while any frame bit is on the line.
- `frame_done` output, 1: one-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset values:
  - `txd`=1, `fifo_pop`=0, `tx_busy`=0, `frame_done`=0.
  - State IDLE; bit counter and cycle counter 0.
- States and transitions:
  - IDLE → START when `fifo_empty`=0.
  - START → DATA.
  - DATA → PARITY if `lcr[3]` is set, else STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if `lcr[2]` is set, else reload-or-IDLE.
  - STOP2 → reload-or-IDLE.
- Load:
  - In IDLE with `fifo_empty`=0, assert `fifo_pop` for exactly one cycle.
  - In that same cycle, capture `fifo_data`, `lcr[5:0]` and `divisor` into frame registers.
  - `lcr` and `divisor` changes mid-frame have no effect until the next load.
- Reload:
  - In the final cycle of the last stop bit, if `fifo_empty`=0, pop and load exactly as above and go to START. Consecutive frames therefore have zero idle gap.
  - Otherwise go to IDLE.
- Bit levels on `txd`:
  - START: 0.
  - DATA: `shift[0]`; shift right once per bit.
  - PARITY: parity bit.
  - STOP1 and STOP2: 1.
  - IDLE: 1.
- Data bits: exactly W = 5 + `lcr[1:0]` data bits are sent. Bits above W-1 are ignored, both for transmission and for parity.
- Parity over the W data bits, where x = XOR of the data bits:
  - Even parity: bit = x.
  - Odd parity: bit = ~x.
  - Stick (`lcr[5]`=1 with `lcr[3]`=1): bit = ~`lcr[4]`.
- Break: `lcr[6]`=1 forces `txd`=0 combinationally-registered. It is the only `lcr` bit read live rather than from the frame registers. The state machine, pops and counters continue unaffected.
- `tx_busy`=1 in START, DATA, PARITY and STOP states; 0 in IDLE.
- Width rules:
  - Cycle counter is `DIV_W` bits and counts 0..N-1, where N = max(`divisor`, 1).
  - Bit counter is 3 bits.

## Timing
- Pop in cycle T0 → `txd` falls to 0 at T0+1 (registered output).
- Every bit is held for exactly N cycles.
- Frame length = (1 + W + P + S) × N cycles, where P = `lcr[3]` and S = 1 + `lcr[2]`.
- `frame_done` is asserted in cycle T0 + frame length, which is also the cycle of any reload pop.
- No pop is ever issued while `fifo_empty`=1, and at most one pop occurs per frame.
- Reset asserted mid-frame:
  - `txd` goes to 1 and `fifo_pop` goes to 0 asynchronously; the partial frame is abandoned.
  - After reset release, the first pop occurs no earlier than the first clock edge.

## Test plan
- 8N1, `divisor`=4, push 0xA5 → one pop; `txd` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total; `frame_done` pulses at cycle 40.
- 7E1 (`lcr`=0x1A), `divisor`=1, byte 0xB5 → data bits 1,0,1,0,1,1,0 (bit 7 ignored), parity 0, one stop bit; 10-cycle frame.
- 5O2 (`lcr`=0x0C), `divisor`=2, byte 0xFF → five 1 data bits, parity 0, two stop bits; 18 cycles total.
- Three bytes 0x01, 0x02, 0x03 pushed back-to-back, 8N1, `divisor`=3 → 3 pops each exactly 30 cycles apart, no idle-high gap, `tx_busy` continuously 1, then IDLE.
- Set `lcr[6]` mid-frame → `txd`=0 throughout the break while the frame count still completes; clear break → `txd` resumes at the current bit level.
- Assert `rstn` low in the DATA state → `txd`=1 immediately, `tx_busy`=0; after release with FIFO non-empty, a fresh frame starts with a new pop.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// FIFO-to-serializer pop handshake.
// master: the TX FIFO (drives empty flag and head data, receives pop).
// slave:  the serializer (consumes head data, issues pop strobes).
interface uart_tx_serializer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;

    modport master (output fifo_empty, output fifo_data, input fifo_pop);
    modport slave  (input fifo_empty, input fifo_data, output fifo_pop);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out
// as start / 5-8 data bits (LSB first) / optional parity / 1-2 stop bits.
// Frame format and bit period are latched at load; only break is read live.
module uart_tx_serializer #(
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    uart_tx_serializer_if.slave  fifo,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [6:0]           lcr,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cyc_q, cyc_d;      // cycle within current bit
    logic [DIV_W-1:0] n_q, n_d;          // cycles per bit, never 0
    logic [2:0]       bit_q, bit_d;      // data bit index
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       wl_q, wl_d;
    logic             stop2_q, stop2_d;
    logic             pen_q, pen_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             run_q;             // blocks pops until the first edge after reset

    logic             bit_end;
    logic             last_data;
    logic             load;
    logic             pop;
    logic             done;
    logic             level;
    logic [7:0]       data_mask;
    logic             data_xor;

    assign bit_end   = (cyc_q == (n_q - ONE));
    // Last data bit index is W-1 = 4 + word-length code.
    assign last_data = (bit_q == {1'b1, wl_q});
    // Parity covers only the W transmitted bits.
    assign data_mask = 8'hFF >> (2'd3 - lcr[1:0]);
    assign data_xor  = ^(fifo.fifo_data & data_mask);

    // Next-state, counters, frame load and registered line level.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        n_d     = n_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wl_d    = wl_q;
        stop2_d = stop2_q;
        pen_d   = pen_q;
        par_d   = par_q;
        load    = 1'b0;
        done    = 1'b0;
        level   = 1'b1;

        if (state_q != S_IDLE)
            cyc_d = bit_end ? '0 : cyc_q + ONE;

        unique case (state_q)
            S_IDLE: begin
                if (run_q && !fifo.fifo_empty)
                    load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_data)
                        state_d = pen_q ? S_PARITY : S_STOP1;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (bit_end)
                    state_d = S_STOP1;
            end
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        done = 1'b1;
                        if (run_q && !fifo.fifo_empty) load = 1'b1;
                        else                           state_d = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (run_q && !fifo.fifo_empty) load = 1'b1;
                    else                           state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load (from idle or back-to-back reload) latches the whole frame.
        if (load) begin
            state_d = S_START;
            cyc_d   = '0;
            bit_d   = 3'd0;
            shift_d = fifo.fifo_data;
            wl_d    = lcr[1:0];
            stop2_d = lcr[2];
            pen_d   = lcr[3];
            n_d     = (divisor == '0) ? ONE : divisor;
            if (lcr[5])      par_d = ~lcr[4];
            else if (lcr[4]) par_d = data_xor;
            else             par_d = ~data_xor;
        end

        unique case (state_d)
            S_START:  level = 1'b0;
            S_DATA:   level = shift_d[0];
            S_PARITY: level = par_d;
            default:  level = 1'b1;
        endcase

        // Break overrides the line but not the frame sequencing.
        txd_d = lcr[6] ? 1'b0 : level;
    end

    assign pop = load;

    // State and frame registers; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            n_q     <= ONE;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            wl_q    <= 2'b00;
            stop2_q <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            n_q     <= n_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wl_q    <= wl_d;
            stop2_q <= stop2_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            run_q   <= 1'b1;
        end
    end

    assign fifo.fifo_pop = pop;
    assign txd           = txd_q;
    assign tx_busy       = (state_q != S_IDLE);
    assign frame_done    = done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: a FIFO model feeds the serializer; a per-cycle
// expected-waveform queue is built from each popped byte's frame format.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] divisor;
    logic [6:0]  lcr;
    logic        txd, tx_busy, frame_done;

    always #5 clk = ~clk;

    uart_tx_serializer_if fif ();

    uart_tx_serializer #(.DIV_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo       (fif.slave),
        .divisor    (divisor),
        .lcr        (lcr),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    typedef struct packed { logic lvl; logic done; } exp_t;

    logic [7:0] fq[$];      // FIFO contents
    exp_t       eq[$];      // expected line per future cycle
    int         popc[$];    // cycle numbers of observed pops
    int         n_chk = 0, n_pass = 0;
    int         cyc_n = 0, pop_cyc = 0, done_cyc = 0;
    logic       armed = 1'b0, prev_brk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic upd_fifo();
        fif.fifo_empty = (fq.size() == 0);
        fif.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        upd_fifo();
    endtask

    // Expected frame straight from the format rules.
    task automatic build(input logic [7:0] b, input logic [5:0] l, input logic [15:0] dv);
        logic bits[$];
        int   w = 5 + int'(l[1:0]);
        int   n = (dv == 0) ? 1 : int'(dv);
        logic x = 1'b0;
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(b[i]);
            x = x ^ b[i];
        end
        if (l[3]) bits.push_back(l[5] ? ~l[4] : (l[4] ? x : ~x));
        bits.push_back(1'b1);
        if (l[2]) bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++)
            for (int c = 0; c < n; c++) begin
                e.lvl  = bits[k];
                e.done = (k == bits.size() - 1) && (c == n - 1);
                eq.push_back(e);
            end
    endtask

    // One clock: check mid-cycle at negedge, then let the FIFO act on a pop.
    task automatic tick();
        exp_t cur;
        logic busy_e, pop_e, pop_seen;
        @(negedge clk);
        cyc_n++;
        if (eq.size() != 0) begin
            cur = eq.pop_front();
            busy_e = 1'b1;
        end else begin
            cur.lvl = 1'b1; cur.done = 1'b0;
            busy_e = 1'b0;
        end
        pop_e = armed && (fq.size() != 0) && (!busy_e || cur.done);
        chk("txd",  32'(txd),        32'(prev_brk ? 1'b0 : cur.lvl));
        chk("busy", 32'(tx_busy),    32'(busy_e));
        chk("done", 32'(frame_done), 32'(cur.done));
        chk("pop",  32'(fif.fifo_pop), 32'(pop_e));
        if (frame_done) done_cyc = cyc_n;
        pop_seen = fif.fifo_pop;
        if (pop_seen && fq.size() != 0) begin
            build(fq[0], lcr[5:0], divisor);
            pop_cyc = cyc_n;
            popc.push_back(cyc_n);
        end
        prev_brk = lcr[6];
        @(posedge clk);
        #1;
        armed = rstn;
        if (pop_seen && fq.size() != 0) void'(fq.pop_front());
        upd_fifo();
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (fq.size() != 0 || eq.size() != 0); i++) tick();
        chk("drain", 32'(fq.size() == 0 && eq.size() == 0), 32'd1);
    endtask

    task automatic hit_reset();
        rstn = 1'b0;
        #1;
        chk("rst_txd",  32'(txd),          32'd1);
        chk("rst_busy", 32'(tx_busy),      32'd0);
        chk("rst_pop",  32'(fif.fifo_pop), 32'd0);
        chk("rst_done", 32'(frame_done),   32'd0);
        eq.delete();
        prev_brk = 1'b0;
        armed = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        lcr = 7'h03; divisor = 16'd4; rstn = 1'b1;
        upd_fifo();
        #2;
        hit_reset();

        // 8N1, divisor 4, 0xA5: 40-cycle frame
        push(8'hA5);
        drain();
        chk("len_8n1", 32'(done_cyc - pop_cyc), 32'd40);

        // 7E1, divisor 1, 0xB5: 10-cycle frame
        lcr = 7'h1A; divisor = 16'd1;
        push(8'hB5);
        drain();
        chk("len_7e1", 32'(done_cyc - pop_cyc), 32'd10);

        // 5O2, divisor 2, 0xFF: 18-cycle frame
        lcr = 7'h0C; divisor = 16'd2;
        push(8'hFF);
        drain();
        chk("len_5o2", 32'(done_cyc - pop_cyc), 32'd18);

        // back-to-back 8N1, divisor 3: pops exactly 30 cycles apart
        lcr = 7'h03; divisor = 16'd3;
        popc.delete();
        push(8'h01); push(8'h02); push(8'h03);
        drain();
        chk("b2b_pops", 32'(popc.size()), 32'd3);
        if (popc.size() == 3) begin
            chk("b2b_gap1", 32'(popc[1] - popc[0]), 32'd30);
            chk("b2b_gap2", 32'(popc[2] - popc[1]), 32'd30);
        end

        // break mid-frame, divisor change mid-frame must not matter
        divisor = 16'd4;
        push(8'h5A);
        for (int i = 0; i < 10; i++) tick();
        lcr[6] = 1'b1; divisor = 16'd7;
        for (int i = 0; i < 12; i++) tick();
        lcr[6] = 1'b0;
        drain();
        divisor = 16'd4;

        // reset during DATA, then a fresh frame from the remaining byte
        push(8'h3C); push(8'h77);
        for (int i = 0; i < 16; i++) tick();
        hit_reset();
        drain();

        // randomized traffic, formats and breaks; divisor 0 acts as 1
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 14) == 0 && fq.size() < 16) push(8'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                lcr[5:0] = 6'($urandom);
                divisor  = 16'($urandom_range(0, 4));
            end
            if (!lcr[6] && $urandom_range(0, 59) == 0) lcr[6] = 1'b1;
            else if (lcr[6] && $urandom_range(0, 4) == 0) lcr[6] = 1'b0;
            tick();
        end
        lcr[6] = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
